// File: rtl/tf_ram_loader.sv
// Streams twiddle coefficients path-major into NUM_PATH write ports and flags a complete table.
// Optional checksum output chk_out is enabled by defining TF_LOAD_CHECKSUM_EN.
module tf_ram_loader #(
  parameter int COE_WIDTH  = 39,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_PATH   = 4
) (
  input  logic                  clka,
  input  logic                  rsta_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [COE_WIDTH-1:0]  s_data,
  output logic                  s_ready,
  output logic [NUM_PATH-1:0]   wea,
  output logic [ADDR_WIDTH-1:0] waddra,
  output logic [COE_WIDTH-1:0]  wdataa,
  output logic                  busy,
  output logic                  done,
`ifdef TF_LOAD_CHECKSUM_EN
  output logic                  tf_ready,
  output logic [COE_WIDTH-1:0]  chk_out
`else
  output logic                  tf_ready
`endif
);

  localparam int PATH_W = (NUM_PATH > 1) ? $clog2(NUM_PATH) : 0;
  localparam int CNT_W  = PATH_W + ADDR_WIDTH;
  // NUM_PATH is a power of two, so the final beat index is all ones.
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    s_ready_q, s_ready_d;
  logic [NUM_PATH-1:0]     wea_q, wea_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [COE_WIDTH-1:0]    wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    tf_ready_q, tf_ready_d;
  logic                    accept_s;
  logic [CNT_W-1:0]        bank_s;
`ifdef TF_LOAD_CHECKSUM_EN
  logic [COE_WIDTH-1:0]    chk_q, chk_d;
`endif

  // A beat coinciding with a restart is dropped; the restart has priority.
  assign accept_s = s_valid & s_ready_q & (state_q == ST_LOAD) & ~start;
  assign bank_s   = cnt_q >> ADDR_WIDTH;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_ready_d  = 1'b0;
    wea_d      = {NUM_PATH{1'b0}};
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    tf_ready_d = tf_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          cnt_d      = {CNT_W{1'b0}};
          tf_ready_d = 1'b0;
          s_ready_d  = 1'b1;
        end else begin
          s_ready_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (start) begin
          cnt_d      = {CNT_W{1'b0}};
          tf_ready_d = 1'b0;
          s_ready_d  = 1'b1;
        end else begin
          s_ready_d = 1'b1;
          if (accept_s) begin
            wea_d   = NUM_PATH'(1'b1) << bank_s;
            waddr_d = cnt_q[ADDR_WIDTH-1:0];
            wdata_d = s_data;
            if (cnt_q == CNT_LAST) begin
              state_d   = ST_FIN;
              s_ready_d = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      ST_FIN: begin
        if (start) begin
          state_d    = ST_LOAD;
          cnt_d      = {CNT_W{1'b0}};
          tf_ready_d = 1'b0;
          s_ready_d  = 1'b1;
        end else begin
          state_d    = ST_IDLE;
          done_d     = 1'b1;
          tf_ready_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tf_ready_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

`ifdef TF_LOAD_CHECKSUM_EN
  // Running XOR of every coefficient presented on the write port this load.
  always_comb begin
    if (start) begin
      chk_d = {COE_WIDTH{1'b0}};
    end else if (wea_q != {NUM_PATH{1'b0}}) begin
      chk_d = chk_q ^ wdata_q;
    end else begin
      chk_d = chk_q;
    end
  end
`endif

  // Loader FSM and output registers.
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      s_ready_q  <= 1'b0;
      wea_q      <= {NUM_PATH{1'b0}};
      waddr_q    <= {ADDR_WIDTH{1'b0}};
      wdata_q    <= {COE_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tf_ready_q <= 1'b0;
`ifdef TF_LOAD_CHECKSUM_EN
      chk_q      <= {COE_WIDTH{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_ready_q  <= s_ready_d;
      wea_q      <= wea_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tf_ready_q <= tf_ready_d;
`ifdef TF_LOAD_CHECKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign s_ready  = s_ready_q;
  assign wea      = wea_q;
  assign waddra   = waddr_q;
  assign wdataa   = wdata_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tf_ready = tf_ready_q;
`ifdef TF_LOAD_CHECKSUM_EN
  assign chk_out  = chk_q;
`endif

endmodule

// File: tb/tb_tf_ram_loader.sv
// Scoreboard bench for tf_ram_loader (ADDR_WIDTH=2, NUM_PATH=4, COE_WIDTH=39).
module tb_tf_ram_loader;

  localparam int CW = 39;
  localparam int AW = 2;
  localparam int NP = 4;

  typedef struct packed {
    logic [NP-1:0] wea;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  logic          clka = 1'b0;
  logic          rsta_n;
  logic          start;
  logic          s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready;
  logic [NP-1:0] wea;
  logic [AW-1:0] waddra;
  logic [CW-1:0] wdataa;
  logic          busy;
  logic          done;
  logic          tf_ready;
`ifdef TF_LOAD_CHECKSUM_EN
  logic [CW-1:0] chk_out;
  logic [CW-1:0] exp_chk;
`endif

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_wea_cyc = 0;
  int  done_cnt = 0;
  bit  mon_en = 1'b0;
  wr_t exp_q[$];

  tf_ram_loader #(.COE_WIDTH(CW), .ADDR_WIDTH(AW), .NUM_PATH(NP)) dut (
    .clka(clka), .rsta_n(rsta_n), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .wea(wea), .waddra(waddra), .wdataa(wdataa), .busy(busy),
    .done(done),
`ifdef TF_LOAD_CHECKSUM_EN
    .tf_ready(tf_ready), .chk_out(chk_out)
`else
    .tf_ready(tf_ready)
`endif
  );

  always #5 clka = ~clka;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every write against the scoreboard and checks done timing.
  always @(negedge clka) begin
    wr_t e;
    cyc++;
    if (mon_en) begin
      if (wea != {NP{1'b0}}) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: wea=%b addr=%0d data=0x%0h, none expected", wea, waddra, wdataa);
        end else begin
          e = exp_q.pop_front();
          check("write_wea", 64'(wea), 64'(e.wea));
          check("write_addr", 64'(waddra), 64'(e.addr));
          check("write_data", 64'(wdataa), 64'(e.data));
        end
        last_wea_cyc = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("done_latency", 64'(cyc - last_wea_cyc), 64'd1);
        check("writes_pending_at_done", 64'(exp_q.size()), 64'd0);
        check("tf_ready_at_done", 64'(tf_ready), 64'd1);
`ifdef TF_LOAD_CHECKSUM_EN
        check("chk_out_at_done", 64'(chk_out), 64'(exp_chk));
`endif
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clka);
    #1;
    start = 1'b0;
`ifdef TF_LOAD_CHECKSUM_EN
    exp_chk = {CW{1'b0}};
`endif
  endtask

  task automatic send_beat(input int k, input logic [CW-1:0] d);
    bit   got = 1'b0;
    logic rdy;
    wr_t  e;
    logic [NP-1:0] one = 4'b0001;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clka);
      rdy = s_ready;
      @(posedge clka);
      #1;
      if (rdy) got = 1'b1;
    end
    s_valid = 1'b0;
    if (got) begin
      e.wea  = one << (k >> AW);
      e.addr = AW'(k);
      e.data = d;
      exp_q.push_back(e);
`ifdef TF_LOAD_CHECKSUM_EN
      exp_chk = exp_chk ^ d;
`endif
    end else begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %0d not accepted within 50 cycles, expected accept", k);
    end
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clka);
    #1;
  endtask

  task automatic wait_done();
    int prev = done_cnt;
    for (int i = 0; i < 10 && done_cnt == prev; i++) @(negedge clka);
    check("done_seen", 64'(done_cnt), 64'(prev + 1));
    @(negedge clka);
    check("tf_ready_after_done", 64'(tf_ready), 64'd1);
    check("busy_after_done", 64'(busy), 64'd0);
    @(posedge clka);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_wea"}, 64'(wea), 64'd0);
    check({tag, "_waddra"}, 64'(waddra), 64'd0);
    check({tag, "_wdataa"}, 64'(wdataa), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_tf_ready"}, 64'(tf_ready), 64'd0);
`ifdef TF_LOAD_CHECKSUM_EN
    check({tag, "_chk_out"}, 64'(chk_out), 64'd0);
`endif
  endtask

  initial begin
    int base;
    rsta_n  = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = {CW{1'b0}};
`ifdef TF_LOAD_CHECKSUM_EN
    exp_chk = {CW{1'b0}};
`endif
    repeat (2) @(posedge clka);
    @(negedge clka);
    check_reset_outputs("reset");
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
    mon_en = 1'b1;

    // 1: full load at one beat per cycle, data = k
    pulse_start();
    @(negedge clka);
    check("busy_after_start", 64'(busy), 64'd1);
    check("s_ready_in_load", 64'(s_ready), 64'd1);
    @(posedge clka);
    #1;
    for (int k = 0; k < 16; k++) send_beat(k, CW'(k));
    @(negedge clka);
    check("s_ready_in_fin", 64'(s_ready), 64'd0);
    check("busy_in_fin", 64'(busy), 64'd1);
    wait_done();

    // 2: same load with s_valid toggling
    pulse_start();
    for (int k = 0; k < 16; k++) begin
      send_beat(k, CW'(k) + 39'h100);
      idle_cycle();
    end
    wait_done();

    // 3 and 5: start from a complete table, abort after 7 beats, reload
    base = done_cnt;
    pulse_start();
    @(negedge clka);
    check("tf_ready_drop_on_start", 64'(tf_ready), 64'd0);
    check("busy_on_start", 64'(busy), 64'd1);
    @(posedge clka);
    #1;
    for (int k = 0; k < 7; k++) send_beat(k, CW'(k) + 39'h200);
    pulse_start();
    for (int k = 0; k < 15; k++) send_beat(k, CW'(k) + 39'h300);
    @(negedge clka);
    check("tf_ready_low_during_reload", 64'(tf_ready), 64'd0);
    @(posedge clka);
    #1;
    send_beat(15, 39'h30F);
    wait_done();
    check("single_done_after_restart", 64'(done_cnt), 64'(base + 1));

    // 4: reset after 9 beats, then stream without start
    pulse_start();
    for (int k = 0; k < 9; k++) send_beat(k, CW'(k) + 39'h400);
    rsta_n = 1'b0;
    @(posedge clka);
    #1;
    rsta_n = 1'b1;
    @(negedge clka);
    check_reset_outputs("midload_reset");
    s_valid = 1'b1;
    s_data  = 39'h7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      check("s_ready_no_start", 64'(s_ready), 64'd0);
      check("busy_no_start", 64'(busy), 64'd0);
    end
    @(posedge clka);
    #1;
    s_valid = 1'b0;

    // 6: data 1..16; XOR of 1..16 is 0x10
    pulse_start();
    for (int k = 0; k < 16; k++) send_beat(k, CW'(k + 1));
`ifdef TF_LOAD_CHECKSUM_EN
    check("checksum_model", 64'(exp_chk), 64'h10);
`endif
    wait_done();
`ifdef TF_LOAD_CHECKSUM_EN
    check("chk_out_final", 64'(chk_out), 64'h10);
`endif

    repeat (3) @(posedge clka);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
